// File: rtl/adc_calib_pkg.sv
// Shared types and helpers for the multi-channel ADC calibrator:
// FSM/point enums, default widths and clamp limit, coefficient record and output clamp.
package adc_calib_pkg;

  localparam int CAL_W      = 16;
  localparam int CAL_FRAC   = 8;
  localparam int CAL_MAX_MV = 9999;

  typedef enum logic [1:0] {IDLE, ACCUM, COMPUTE, DONE} cal_state_t;

  typedef enum logic {LO, HI} cal_point_t;

  // Gain is unsigned fixed point with CAL_FRAC fractional bits (max just under 4.0).
  typedef struct packed {
    logic [CAL_W-1:0]    ref_lo;
    logic [CAL_W-1:0]    meas_lo;
    logic [CAL_FRAC+1:0] gain;
  } cal_coeff_t;

  function automatic logic [31:0] clamp_mv(input logic signed [63:0] v,
                                           input logic [31:0]        max_mv);
    if (v < 64'sd0)
      return 32'd0;
    else if (v > $signed({32'd0, max_mv}))
      return max_mv;
    else
      return v[31:0];
  endfunction

endpackage

// File: rtl/adc_calib_div.sv
// Sequential restoring unsigned divider, one quotient bit per cycle; done pulses
// NW+1 cycles after start. Saturation of the quotient is left to the caller.
module adc_calib_div
  import adc_calib_pkg::*;
#(
  parameter int NW = CAL_W + CAL_FRAC,
  parameter int DW = CAL_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [NW-1:0] num,
  input  logic [DW-1:0] den,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] quo
);

  localparam int CNTW = $clog2(NW + 1);

  logic [DW-1:0]   rem;
  logic [DW-1:0]   den_q;
  logic [CNTW-1:0] cnt;
  logic [DW:0]     shifted;

  // The quotient register doubles as the numerator shift register.
  assign shifted = {rem, quo[NW-1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      rem   <= '0;
      den_q <= '0;
      quo   <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        busy  <= 1'b1;
        rem   <= '0;
        quo   <= num;
        den_q <= den;
        cnt   <= CNTW'(NW);
      end else if (busy) begin
        if (shifted >= {1'b0, den_q}) begin
          rem <= DW'(shifted - {1'b0, den_q});
          quo <= {quo[NW-2:0], 1'b1};
        end else begin
          rem <= shifted[DW-1:0];
          quo <= {quo[NW-2:0], 1'b0};
        end
        cnt <= cnt - CNTW'(1);
        if (cnt == CNTW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/adc_multi_calib.sv
// N-channel ADC calibrator: averages calibration points against the reference and corrects
// every sample. Define ADC_CAL_TWO_POINT_EN to add hi-point capture, the divider and gain.
module adc_multi_calib
  import adc_calib_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int W        = CAL_W,
  parameter int AVG_LOG2 = 4,
  parameter int FRAC     = CAL_FRAC,
  parameter int MAX_MV   = CAL_MAX_MV
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cal_lo_btn,
  input  logic              cal_hi_btn,
  input  logic              sample_valid,
  input  logic [W-1:0]      ref_mV,
  input  logic [N_CH*W-1:0] meas_mV,
  output logic [N_CH*W-1:0] corr_mV,
  output logic              corr_valid,
  output logic              cal_busy,
  output logic              cal_done,
  output logic              cal_err
);

  localparam int CW = W + FRAC + 3;
  localparam int SW = W + AVG_LOG2;
  localparam int GW = FRAC + 2;
  localparam logic [GW-1:0] GAIN_ONE = GW'(1 << FRAC);

  cal_state_t          state, state_next;
  cal_point_t          point;
  cal_coeff_t          coeff [N_CH];
  cal_coeff_t          stage [N_CH];
  logic [SW-1:0]       sum_ref;
  logic [SW-1:0]       sum_meas [N_CH];
  logic [AVG_LOG2-1:0] cnt;
  logic [W-1:0]        avg_ref;
  logic [W-1:0]        avg_meas [N_CH];
  logic [2:0]          lo_sr;
  logic                lo_edge, hi_edge, start_cal;

  // Two synchroniser flops plus one history flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) lo_sr <= '0;
    else       lo_sr <= {lo_sr[1:0], cal_lo_btn};
  end
  assign lo_edge = lo_sr[1] & ~lo_sr[2];

`ifdef ADC_CAL_TWO_POINT_EN
  logic [2:0] hi_sr;
  always_ff @(posedge clk) begin
    if (reset) hi_sr <= '0;
    else       hi_sr <= {hi_sr[1:0], cal_hi_btn};
  end
  assign hi_edge = hi_sr[1] & ~hi_sr[2];
`else
  logic unused_hi_btn;
  assign unused_hi_btn = cal_hi_btn;
  assign hi_edge       = 1'b0;
`endif

  assign start_cal = (state == IDLE) && (lo_edge || hi_edge);

  always_comb begin
    avg_ref = sum_ref[SW-1:AVG_LOG2];
    for (int i = 0; i < N_CH; i++) avg_meas[i] = sum_meas[i][SW-1:AVG_LOG2];
  end

`ifdef ADC_CAL_TWO_POINT_EN
  localparam int NW  = W + FRAC;
  localparam int CYW = $clog2(W + FRAC + 2);
  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CYW-1:0] CYC_LAST = CYW'(W + FRAC + 1);

  logic [CHW-1:0] ch;
  logic [CYW-1:0] cyc;
  logic           err_flag;
  logic [W:0]     span_m, span_r;
  logic           span_ok, last_step, div_start, div_busy, div_done;
  logic [NW-1:0]  div_quo;

  // Spans are one bit wider than W so a negative span shows up in the MSB.
  always_comb begin
    span_m  = {1'b0, avg_meas[ch]} - {1'b0, stage[ch].meas_lo};
    span_r  = {1'b0, avg_ref} - {1'b0, stage[ch].ref_lo};
    span_ok = !span_m[W] && (span_m != '0) && !span_r[W] && (span_r != '0);
  end

  assign last_step = (ch == CHW'(N_CH - 1)) && (cyc == CYC_LAST);
  assign div_start = (state == COMPUTE) && (point == HI) && (cyc == '0) && span_ok && !div_busy;

  adc_calib_div #(.NW(NW), .DW(W)) u_div (
    .clk   (clk),
    .reset (reset),
    .start (div_start),
    .num   ({span_r[W-1:0], {FRAC{1'b0}}}),
    .den   (span_m[W-1:0]),
    .busy  (div_busy),
    .done  (div_done),
    .quo   (div_quo)
  );

  function automatic logic [GW-1:0] sat_gain(input logic [NW-1:0] q);
    if (|q[NW-1:GW]) return '1;
    return q[GW-1:0];
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    cal_busy   = 1'b0;
    cal_done   = 1'b0;
    cal_err    = 1'b0;
    case (state)
      IDLE: if (start_cal) state_next = ACCUM;
      ACCUM: begin
        cal_busy = 1'b1;
        if (sample_valid && (cnt == '1)) state_next = COMPUTE;
      end
      COMPUTE: begin
        cal_busy = 1'b1;
`ifdef ADC_CAL_TWO_POINT_EN
        if ((point == LO) || last_step) state_next = DONE;
`else
        state_next = DONE;
`endif
      end
      DONE: begin
        cal_done = 1'b1;
`ifdef ADC_CAL_TWO_POINT_EN
        cal_err  = err_flag;
`endif
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // New coefficients build up in stage[] and are committed together in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      point   <= LO;
      cnt     <= '0;
      sum_ref <= '0;
      for (int i = 0; i < N_CH; i++) begin
        sum_meas[i] <= '0;
        coeff[i]    <= '{ref_lo: '0, meas_lo: '0, gain: GAIN_ONE};
        stage[i]    <= '{ref_lo: '0, meas_lo: '0, gain: GAIN_ONE};
      end
`ifdef ADC_CAL_TWO_POINT_EN
      ch       <= '0;
      cyc      <= '0;
      err_flag <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start_cal) begin
          point   <= lo_edge ? LO : HI;
          cnt     <= '0;
          sum_ref <= '0;
          for (int i = 0; i < N_CH; i++) begin
            sum_meas[i] <= '0;
            stage[i]    <= coeff[i];
          end
`ifdef ADC_CAL_TWO_POINT_EN
          ch       <= '0;
          cyc      <= '0;
          err_flag <= 1'b0;
`endif
        end
        ACCUM: if (sample_valid) begin
          cnt     <= cnt + AVG_LOG2'(1);
          sum_ref <= sum_ref + SW'(ref_mV);
          for (int i = 0; i < N_CH; i++)
            sum_meas[i] <= sum_meas[i] + SW'(meas_mV[i*W +: W]);
        end
        COMPUTE: begin
          if (point == LO) begin
            for (int i = 0; i < N_CH; i++) begin
              stage[i].ref_lo  <= avg_ref;
              stage[i].meas_lo <= avg_meas[i];
            end
          end
`ifdef ADC_CAL_TWO_POINT_EN
          else begin
            if ((cyc == '0) && !span_ok) err_flag <= 1'b1;
            if (cyc == CYC_LAST) begin
              if (span_ok && div_done) stage[ch].gain <= sat_gain(div_quo);
              cyc <= '0;
              ch  <= ch + CHW'(1);
            end else begin
              cyc <= cyc + CYW'(1);
            end
          end
`endif
        end
        DONE: for (int i = 0; i < N_CH; i++) coeff[i] <= stage[i];
        default: ;
      endcase
    end
  end

  function automatic logic [W-1:0] correct(input logic [W-1:0] m, input cal_coeff_t k);
    logic signed [CW-1:0] d, g, p, c;
    d = $signed({{(CW-W){1'b0}}, m}) - $signed({{(CW-W){1'b0}}, k.meas_lo});
    g = $signed({{(CW-GW){1'b0}}, k.gain});
    p = (d * g) >>> FRAC;
    c = $signed({{(CW-W){1'b0}}, k.ref_lo}) + p;
    return W'(clamp_mv(64'(c), 32'(MAX_MV)));
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      corr_mV    <= '0;
      corr_valid <= 1'b0;
    end else begin
      corr_valid <= sample_valid;
      if (sample_valid)
        for (int i = 0; i < N_CH; i++)
          corr_mV[i*W +: W] <= correct(meas_mV[i*W +: W], coeff[i]);
    end
  end

endmodule
